// File: rtl/mcse_lc_auth_ctrl.sv
// Lifecycle transition controller: request, authenticate through the shared SHA engine,
// and commit a forward-only LC state change on digest match, with timeout and lockout.
module mcse_lc_auth_ctrl #(
  parameter int ID_W           = 256,
  parameter int NUM_LC         = 4,
  parameter int LC_W           = $clog2(NUM_LC),
  parameter int LC_RESET_STATE = 0,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int AUTH_TIMEOUT   = 1024,
  parameter int CNT_W          = $clog2(AUTH_TIMEOUT + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                lc_transition_request,
  input  logic [LC_W-1:0]                     lc_transition_target,
  input  logic [ID_W-1:0]                     lc_transition_id,
  input  logic [ID_W-1:0]                     lc_authentication_id,
  input  logic                                lc_authentication_valid,
  input  logic                                hash_ready,
  output logic                                hash_start,
  output logic [ID_W-1:0]                     hash_msg,
  input  logic                                hash_digest_valid,
  input  logic [ID_W-1:0]                     hash_digest,
  output logic [LC_W-1:0]                     lc_state,
  output logic                                lc_busy,
  output logic                                lc_done,
  output logic                                lc_error,
  output logic [2:0]                          lc_err_code,
  output logic                                lc_locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   lc_attempts
);

  localparam int AT_W = $clog2(MAX_ATTEMPTS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_AUTH, S_HASH_REQ, S_HASH_WAIT, S_COMMIT, S_LOCKED
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_ILLEGAL = 3'd1, ERR_TIMEOUT = 3'd2,
    ERR_MISMATCH = 3'd3, ERR_LOCKED = 3'd4
  } err_e;

  state_e            state_q, state_d;
  logic [LC_W-1:0]   lc_state_q, lc_state_d;
  logic [LC_W-1:0]   target_q, target_d;
  logic [ID_W-1:0]   tid_q, tid_d;
  logic [ID_W-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AT_W-1:0]   attempts_q, attempts_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  err_e              code_q, code_d;
  logic              fail;
  err_e              fail_code;
  logic              legal;

  // Forward-only: the target must be strictly more deployed and exist.
  assign legal = (lc_transition_target > lc_state_q) &&
                 (int'(lc_transition_target) < NUM_LC);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    lc_state_d = lc_state_q;
    target_d   = target_q;
    tid_d      = tid_q;
    msg_d      = msg_q;
    cnt_d      = cnt_q;
    attempts_d = attempts_q;
    code_d     = code_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    hash_start = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;

    case (state_q)
      S_IDLE: begin
        if (lc_transition_request) begin
          target_d = lc_transition_target;
          tid_d    = lc_transition_id;
          if (legal) begin
            state_d = S_WAIT_AUTH;
            cnt_d   = '0;
          end else begin
            error_d = 1'b1;
            code_d  = ERR_ILLEGAL;
          end
        end
      end
      S_WAIT_AUTH: begin
        cnt_d = cnt_q + 1'b1;
        // A late authentication on the final cycle still beats the timeout.
        if (lc_authentication_valid) begin
          msg_d   = lc_authentication_id;
          state_d = S_HASH_REQ;
        end else if (cnt_q == CNT_W'(AUTH_TIMEOUT - 1)) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      S_HASH_REQ: begin
        if (hash_ready) begin
          hash_start = 1'b1;
          state_d    = S_HASH_WAIT;
        end
      end
      S_HASH_WAIT: begin
        if (hash_digest_valid) begin
          if (hash_digest == tid_q) begin
            state_d = S_COMMIT;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_MISMATCH;
          end
        end
      end
      S_COMMIT: begin
        lc_state_d = target_q;
        done_d     = 1'b1;
        attempts_d = '0;
        code_d     = ERR_NONE;
        state_d    = S_IDLE;
      end
      S_LOCKED: begin
        if (lc_transition_request) begin
          error_d = 1'b1;
          code_d  = ERR_LOCKED;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      error_d    = 1'b1;
      code_d     = fail_code;
      attempts_d = attempts_q + 1'b1;
      state_d    = (attempts_q == AT_W'(MAX_ATTEMPTS - 1)) ? S_LOCKED : S_IDLE;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk) begin
    // NOTE: the latched IDs are plain registers, not a memory, so they are reset and hash_msg reads 0.
    if (rst) begin
      state_q    <= S_IDLE;
      lc_state_q <= LC_W'(LC_RESET_STATE);
      target_q   <= '0;
      tid_q      <= '0;
      msg_q      <= '0;
      cnt_q      <= '0;
      attempts_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      lc_state_q <= lc_state_d;
      target_q   <= target_d;
      tid_q      <= tid_d;
      msg_q      <= msg_d;
      cnt_q      <= cnt_d;
      attempts_q <= attempts_d;
      done_q     <= done_d;
      error_q    <= error_d;
      code_q     <= code_d;
    end
  end

  assign hash_msg    = msg_q;
  assign lc_state    = lc_state_q;
  assign lc_busy     = (state_q == S_WAIT_AUTH) || (state_q == S_HASH_REQ) ||
                       (state_q == S_HASH_WAIT) || (state_q == S_COMMIT);
  assign lc_done     = done_q;
  assign lc_error    = error_q;
  assign lc_err_code = code_q;
  assign lc_locked   = (state_q == S_LOCKED);
  assign lc_attempts = attempts_q;

endmodule

// File: tb/tb_mcse_lc_auth_ctrl.sv
// Directed bench for mcse_lc_auth_ctrl: a reference model predicts each transaction's
// outcome into a queue, which is popped when the DUT reports done or error.
module tb_mcse_lc_auth_ctrl;

  localparam int ID_W   = 256;
  localparam int NUM_LC = 4;
  localparam int LC_W   = 2;
  localparam int MAX_AT = 3;
  localparam int TO     = 16;
  localparam int AT_W   = 2;

  logic             clk;
  logic             rst;
  logic             lc_transition_request;
  logic [LC_W-1:0]  lc_transition_target;
  logic [ID_W-1:0]  lc_transition_id;
  logic [ID_W-1:0]  lc_authentication_id;
  logic             lc_authentication_valid;
  logic             hash_ready;
  logic             hash_start;
  logic [ID_W-1:0]  hash_msg;
  logic             hash_digest_valid;
  logic [ID_W-1:0]  hash_digest;
  logic [LC_W-1:0]  lc_state;
  logic             lc_busy;
  logic             lc_done;
  logic             lc_error;
  logic [2:0]       lc_err_code;
  logic             lc_locked;
  logic [AT_W-1:0]  lc_attempts;

  mcse_lc_auth_ctrl #(
    .ID_W(ID_W), .NUM_LC(NUM_LC), .LC_RESET_STATE(0),
    .MAX_ATTEMPTS(MAX_AT), .AUTH_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .lc_transition_request(lc_transition_request),
    .lc_transition_target(lc_transition_target),
    .lc_transition_id(lc_transition_id),
    .lc_authentication_id(lc_authentication_id),
    .lc_authentication_valid(lc_authentication_valid),
    .hash_ready(hash_ready), .hash_start(hash_start), .hash_msg(hash_msg),
    .hash_digest_valid(hash_digest_valid), .hash_digest(hash_digest),
    .lc_state(lc_state), .lc_busy(lc_busy), .lc_done(lc_done),
    .lc_error(lc_error), .lc_err_code(lc_err_code), .lc_locked(lc_locked),
    .lc_attempts(lc_attempts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            done;
    logic            err;
    logic [2:0]      code;
    logic [LC_W-1:0] st;
    logic [AT_W-1:0] att;
    logic            locked;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  int              start_cnt = 0;
  int              w;
  logic [LC_W-1:0] m_state;
  int              m_att;
  bit              m_locked;
  logic [2:0]      m_code;
  logic [ID_W-1:0] a_mid;

  always @(posedge clk) if (hash_start) start_cnt++;

  task automatic check(input string tag, input logic [ID_W-1:0] obs, input logic [ID_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Stand-in for SHA: byte rotate plus a fixed mask.
  function automatic logic [ID_W-1:0] sha(input logic [ID_W-1:0] m);
    return {m[ID_W-9:0], m[ID_W-1:ID_W-8]} ^ {8{32'hA5C3_0F1E}};
  endfunction

  task automatic do_reset();
    lc_transition_request   = 1'b0;
    lc_authentication_valid = 1'b0;
    hash_digest_valid       = 1'b0;
    hash_ready              = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_state = '0; m_att = 0; m_locked = 1'b0; m_code = 3'd0;
    sb.delete();
  endtask

  task automatic wait_outcome(output int n);
    exp_t e;
    n = 0;
    while (!(lc_done || lc_error) && n < 200) begin
      tick();
      n++;
    end
    check("outcome_seen", lc_done | lc_error, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("done",     lc_done,     e.done);
      check("error",    lc_error,    e.err);
      check("err_code", lc_err_code, e.code);
      check("lc_state", lc_state,    e.st);
      check("attempts", lc_attempts, e.att);
      check("locked",   lc_locked,   e.locked);
    end
    tick();
    check("pulse_drop", {lc_done, lc_error}, 0);
    check("idle_busy",  lc_busy, 0);
    check("code_held",  lc_err_code, m_code);
  endtask

  // delay < 0 means the authentication never arrives.
  task automatic transact(input logic [LC_W-1:0] tgt, input int delay, input bit corrupt,
                          input int stall, output int n);
    exp_t            e;
    logic [ID_W-1:0] a;
    bit              go;
    int              s0;
    a  = {8{$urandom()}};
    e  = '0;
    go = 1'b0;
    if (m_locked) begin
      e.err = 1'b1; m_code = 3'd4;
    end else if (tgt <= m_state) begin
      e.err = 1'b1; m_code = 3'd1;
    end else begin
      go = 1'b1;
      if (delay < 0 || corrupt) begin
        e.err  = 1'b1;
        m_code = (delay < 0) ? 3'd2 : 3'd3;
        m_att++;
        if (m_att == MAX_AT) m_locked = 1'b1;
      end else begin
        e.done = 1'b1; m_state = tgt; m_att = 0; m_code = 3'd0;
      end
    end
    e.code = m_code; e.st = m_state; e.att = AT_W'(m_att); e.locked = m_locked;
    sb.push_back(e);

    lc_transition_request   = 1'b1;
    lc_transition_target    = tgt;
    lc_transition_id        = sha(a);
    tick();
    lc_transition_request   = 1'b0;
    lc_transition_id        = '1;
    if (go) begin
      check("busy_after_accept", lc_busy, 1);
      if (delay >= 0) begin
        repeat (delay) tick();
        lc_authentication_valid = 1'b1;
        lc_authentication_id    = a;
        hash_ready              = (stall == 0);
        tick();
        lc_authentication_valid = 1'b0;
        lc_authentication_id    = '0;
        s0 = start_cnt;
        for (int i = 0; i < stall; i++) begin
          check("start_stalled", hash_start, 0);
          tick();
        end
        hash_ready = 1'b1;
        #1;
        check("start_on_ready", hash_start, 1);
        check("hash_msg", hash_msg, a);
        tick();
        check("start_single", hash_start, 0);
        check("start_pulses", start_cnt - s0, 1);
        repeat (2) tick();
        hash_digest_valid = 1'b1;
        hash_digest       = corrupt ? (sha(a) ^ ID_W'(1)) : sha(a);
        tick();
        hash_digest_valid = 1'b0;
      end
    end
    wait_outcome(n);
  endtask

  initial begin
    rst = 1'b1;
    lc_transition_request   = 1'b0;
    lc_transition_target    = '0;
    lc_transition_id        = '0;
    lc_authentication_id    = '0;
    lc_authentication_valid = 1'b0;
    hash_ready              = 1'b1;
    hash_digest_valid       = 1'b0;
    hash_digest             = '0;
    tick();
    do_reset();

    check("rst_state",    lc_state, 0);
    check("rst_busy",     lc_busy, 0);
    check("rst_done_err", {lc_done, lc_error}, 0);
    check("rst_code",     lc_err_code, 0);
    check("rst_locked",   lc_locked, 0);
    check("rst_attempts", lc_attempts, 0);
    check("rst_hash_msg", hash_msg, 0);
    check("rst_start",    hash_start, 0);

    transact(2'd1, 5, 1'b0, 0, w);
    transact(2'd2, 0, 1'b0, 0, w);
    transact(2'd1, 0, 1'b0, 0, w);
    check("illegal_latency", w, 0);
    transact(2'd2, 0, 1'b0, 0, w);
    transact(2'd3, -1, 1'b0, 0, w);
    check("timeout_latency", w, TO);
    transact(2'd3, TO - 1, 1'b0, 10, w);
    transact(2'd0, 0, 1'b0, 0, w);
    transact(2'd3, 0, 1'b0, 0, w);

    do_reset();
    transact(2'd1, 2, 1'b1, 0, w);
    transact(2'd1, 2, 1'b1, 0, w);
    transact(2'd1, 2, 1'b1, 0, w);
    transact(2'd2, 0, 1'b0, 0, w);
    check("still_locked", lc_locked, 1);
    do_reset();
    check("unlock_locked", lc_locked, 0);
    check("unlock_state",  lc_state, 0);
    check("unlock_att",    lc_attempts, 0);

    hash_digest_valid = 1'b1;
    hash_digest       = '0;
    tick();
    hash_digest_valid = 1'b0;
    check("stray_digest", {lc_done, lc_error, lc_busy}, 0);

    a_mid = {8{$urandom()}};
    lc_transition_request = 1'b1;
    lc_transition_target  = 2'd1;
    lc_transition_id      = sha(a_mid);
    tick();
    lc_transition_request   = 1'b0;
    lc_authentication_valid = 1'b1;
    lc_authentication_id    = a_mid;
    tick();
    lc_authentication_valid = 1'b0;
    tick();
    check("mid_in_flight", lc_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy",  lc_busy, 0);
    check("mid_state", lc_state, 0);
    check("mid_done",  lc_done, 0);
    hash_digest_valid = 1'b1;
    hash_digest       = sha(a_mid);
    tick();
    hash_digest_valid = 1'b0;
    check("late_digest", {lc_done, lc_error, lc_busy}, 0);
    tick();
    check("late_state", lc_state, 0);
    check("late_done",  lc_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
